// File: rtl/fetch_group_buffer.sv
// Circular instruction buffer and fetch sequencer feeding a 4-wide issue stage.
// Optional performance counters are enabled by defining FGB_PERF_CNT_EN.
module fetch_group_buffer #(
  parameter int unsigned DEPTH    = 8,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] fetch_addr,
  input  logic        fetch_valid,
  input  logic [31:0] fetch_instr0,
  input  logic [31:0] fetch_instr1,
  input  logic [31:0] fetch_instr2,
  input  logic [31:0] fetch_instr3,
  output logic        fetch_ready,
  input  logic [2:0]  issue_cnt,
  input  logic        hold,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic [31:0] Instr1,
  output logic [31:0] Instr2,
  output logic [31:0] Instr3,
  output logic [31:0] Instr4,
  output logic [3:0]  slot_valid,
`ifdef FGB_PERF_CNT_EN
  output logic [31:0] perf_empty_cyc,
  output logic [31:0] perf_issued,
`endif
  output logic [31:0] head_pc
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic {RUN, FLUSH} state_e;

  state_e             state_q, state_d;
  logic [PTR_W-1:0]   head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [31:0]        fetch_addr_q, fetch_addr_d;
  logic [31:0]        head_pc_q, head_pc_d;
  logic [31:0]        mem_q [DEPTH];

  logic [31:0]        wdata [4];
  logic [31:0]        rdata [4];
  logic [CNT_W-1:0]   issue_eff;
  logic [CNT_W-1:0]   deq;
  logic               enq;

  assign wdata[0] = fetch_instr0;
  assign wdata[1] = fetch_instr1;
  assign wdata[2] = fetch_instr2;
  assign wdata[3] = fetch_instr3;

  assign fetch_ready = (state_q == RUN) && (count_q <= CNT_W'(DEPTH - 4)) && !redirect;
  assign enq         = fetch_valid && fetch_ready;

  // issue_cnt 5..7 saturate to 4; retirement never exceeds what is buffered
  always_comb begin
    issue_eff = issue_cnt[2] ? CNT_W'(4) : CNT_W'(issue_cnt);
    deq       = '0;
    if (!hold && !redirect)
      deq = (issue_eff > count_q) ? count_q : issue_eff;
  end

  always_comb begin
    for (int unsigned i = 0; i < 4; i++) begin
      rdata[i]      = '0;
      slot_valid[i] = 1'b0;
      if (count_q > CNT_W'(i)) begin
        rdata[i]      = mem_q[head_q + PTR_W'(i)];
        slot_valid[i] = 1'b1;
      end
    end
  end

  assign Instr1     = rdata[0];
  assign Instr2     = rdata[1];
  assign Instr3     = rdata[2];
  assign Instr4     = rdata[3];
  assign fetch_addr = fetch_addr_q;
  assign head_pc    = head_pc_q;

  always_comb begin
    state_d      = state_q;
    head_d       = head_q;
    tail_d       = tail_q;
    count_d      = count_q;
    fetch_addr_d = fetch_addr_q;
    head_pc_d    = head_pc_q;
    if (redirect) begin
      state_d      = FLUSH;
      head_d       = '0;
      tail_d       = '0;
      count_d      = '0;
      fetch_addr_d = redirect_pc;
      head_pc_d    = redirect_pc;
    end else begin
      if (state_q == FLUSH) state_d = RUN;
      if (enq) begin
        tail_d       = tail_q + PTR_W'(4);
        fetch_addr_d = fetch_addr_q + 32'd16;
      end
      head_d    = head_q + PTR_W'(deq);
      head_pc_d = head_pc_q + 32'({deq, 2'b00});
      count_d   = count_q + (enq ? CNT_W'(4) : '0) - deq;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= RUN;
      head_q       <= '0;
      tail_q       <= '0;
      count_q      <= '0;
      fetch_addr_q <= RESET_PC;
      head_pc_q    <= RESET_PC;
    end else begin
      state_q      <= state_d;
      head_q       <= head_d;
      tail_q       <= tail_d;
      count_q      <= count_d;
      fetch_addr_q <= fetch_addr_d;
      head_pc_q    <= head_pc_d;
    end
  end

  // Storage needs no reset: count gates every read
  always_ff @(posedge clk) begin
    if (enq) begin
      for (int unsigned i = 0; i < 4; i++)
        mem_q[tail_q + PTR_W'(i)] <= wdata[i];
    end
  end

`ifdef FGB_PERF_CNT_EN
  logic [31:0] perf_empty_q, perf_issued_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_empty_q  <= '0;
      perf_issued_q <= '0;
    end else begin
      if ((state_q == RUN) && (count_q == '0) && !redirect)
        perf_empty_q <= perf_empty_q + 32'd1;
      perf_issued_q <= perf_issued_q + 32'(deq);
    end
  end

  assign perf_empty_cyc = perf_empty_q;
  assign perf_issued    = perf_issued_q;
`endif

endmodule
